// File: rtl/countdown_timer.sv
// Countdown timer with load, start/stop (pause) control and a registered
// terminal-count pulse. Runs one-shot by default; auto-reload on terminal
// count is compiled in only when COUNTDOWN_TIMER_AUTORELOAD_EN is defined.
// Priority: rst_i > clrSync_i > stop_i > terminal count > start_i > load_i.
module countdown_timer #(
  parameter int unsigned BW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clrSync_i,
  input  logic          load_i,
  input  logic [BW-1:0] loadVal_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          reload_i,
  output logic [BW-1:0] count_o,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] count_q, count_d;
  logic [BW-1:0] reload_q, reload_d;
  logic          done_q, done_d;
  logic          auto_reload;
  logic          count_zero;
  logic          count_one;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  assign auto_reload = reload_i;
`else
  // reload_i stays on the port for drop-in compatibility but has no effect.
  logic unused_reload;
  assign unused_reload = reload_i;
  assign auto_reload   = 1'b0;
`endif

  assign count_zero = (count_q == '0);
  assign count_one  = (count_q == BW'(1));

  // State, count, reload value and done pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update in priority order.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (clrSync_i) begin
      state_d  = IDLE;
      count_d  = '0;
      reload_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (!count_zero) begin
              state_d = RUN;
            end else begin
              done_d = 1'b1;
            end
          end else if (load_i) begin
            count_d  = loadVal_i;
            reload_d = loadVal_i;
          end
        end
        RUN: begin
          if (stop_i) begin
            state_d = PAUSED;
          end else if (count_one) begin
            done_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end else if (count_zero) begin
            // Defensive: never wrap from zero to all-ones.
            state_d = IDLE;
          end else begin
            count_d = count_q - BW'(1);
          end
        end
        PAUSED: begin
          if (start_i && !count_zero) begin
            state_d = RUN;
          end else if (load_i) begin
            count_d  = loadVal_i;
            reload_d = loadVal_i;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign count_o = count_q;
  assign busy_o  = (state_q == RUN);
  assign done_o  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer (BW=8): per-cycle vector table plus
// hand-written sequences for asynchronous reset and auto-reload.
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       ld;
  logic [7:0] val;
  logic       st;
  logic       sp;
  logic       rl;
  logic [7:0] cnt;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  countdown_timer #(.BW(8)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clrSync_i(clr),
    .load_i   (ld),
    .loadVal_i(val),
    .start_i  (st),
    .stop_i   (sp),
    .reload_i (rl),
    .count_o  (cnt),
    .busy_o   (busy),
    .done_o   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       ld;
    logic [7:0] val;
    logic       st;
    logic       sp;
    logic       rl;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic c, input logic l, input logic [7:0] v,
                              input logic s, input logic p, input logic r,
                              input logic [7:0] ec, input logic eb, input logic ed);
    vec_t x;
    x.clr = c; x.ld = l; x.val = v; x.st = s; x.sp = p; x.rl = r;
    x.cnt = ec; x.busy = eb; x.done = ed;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic [7:0] v,
                       input logic s, input logic p, input logic r);
    @(negedge clk);
    clr = c; ld = l; val = v; st = s; sp = p; rl = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] ec, input logic eb, input logic ed);
    check({tag, " count"}, cnt, ec);
    check({tag, " busy"}, {7'd0, busy}, {7'd0, eb});
    check({tag, " done"}, {7'd0, done}, {7'd0, ed});
  endtask

  initial begin
    // clr ld val st sp rl | cnt busy done   (one record per clock)
    // load 5, run to terminal count
    add(0,1,8'd5, 0,0,0, 8'd5, 0,0);
    add(0,0,8'd0, 1,0,0, 8'd5, 1,0);
    add(0,0,8'd0, 0,0,0, 8'd4, 1,0);
    add(0,0,8'd0, 0,0,0, 8'd3, 1,0);
    add(0,0,8'd0, 0,0,0, 8'd2, 1,0);
    add(0,0,8'd0, 0,0,0, 8'd1, 1,0);
    add(0,0,8'd0, 0,0,0, 8'd0, 0,1);
    add(0,0,8'd0, 0,0,0, 8'd0, 0,0);
    // load 10, pause at 7 for 4 cycles, resume, load during RUN ignored
    add(0,1,8'd10,0,0,0, 8'd10,0,0);
    add(0,0,8'd0, 1,0,0, 8'd10,1,0);
    add(0,0,8'd0, 0,0,0, 8'd9, 1,0);
    add(0,0,8'd0, 0,0,0, 8'd8, 1,0);
    add(0,0,8'd0, 0,0,0, 8'd7, 1,0);
    add(0,0,8'd0, 0,1,0, 8'd7, 0,0);
    add(0,0,8'd0, 0,0,0, 8'd7, 0,0);
    add(0,0,8'd0, 0,0,0, 8'd7, 0,0);
    add(0,0,8'd0, 0,0,0, 8'd7, 0,0);
    add(0,0,8'd0, 1,0,0, 8'd7, 1,0);
    add(0,0,8'd0, 0,0,0, 8'd6, 1,0);
    add(0,1,8'd99,0,0,0, 8'd5, 1,0);
    add(0,0,8'd0, 0,0,0, 8'd4, 1,0);
    // pause, load while paused, stop at count 1 suppresses done
    add(0,0,8'd0, 0,1,0, 8'd4, 0,0);
    add(0,1,8'd2, 0,0,0, 8'd2, 0,0);
    add(0,0,8'd0, 1,0,0, 8'd2, 1,0);
    add(0,0,8'd0, 0,0,0, 8'd1, 1,0);
    add(0,0,8'd0, 0,1,0, 8'd1, 0,0);
    add(0,0,8'd0, 1,0,0, 8'd1, 1,0);
    add(0,0,8'd0, 0,0,0, 8'd0, 0,1);
    add(0,0,8'd0, 0,0,0, 8'd0, 0,0);
    // start with count 0: single done, never busy
    add(0,0,8'd0, 1,0,0, 8'd0, 0,1);
    add(0,0,8'd0, 0,0,0, 8'd0, 0,0);
    // stop+start together in RUN -> PAUSED
    add(0,1,8'd3, 0,0,0, 8'd3, 0,0);
    add(0,0,8'd0, 1,0,0, 8'd3, 1,0);
    add(0,0,8'd0, 1,1,0, 8'd3, 0,0);
    add(0,0,8'd0, 1,0,0, 8'd3, 1,0);
    // synchronous clear at count 2 mid-RUN
    add(0,0,8'd0, 0,0,0, 8'd2, 1,0);
    add(1,0,8'd0, 0,0,0, 8'd0, 0,0);
    add(0,0,8'd0, 1,0,0, 8'd0, 0,1);
    add(0,0,8'd0, 0,0,0, 8'd0, 0,0);
    // clear beats start
    add(0,1,8'd4, 0,0,0, 8'd4, 0,0);
    add(1,0,8'd0, 1,0,0, 8'd0, 0,0);
    add(0,0,8'd0, 0,0,0, 8'd0, 0,0);

    rst = 1'b1; clr = 0; ld = 0; val = '0; st = 0; sp = 0; rl = 0;
    #12;
    check_all("reset", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].val, vecs[i].st, vecs[i].sp, vecs[i].rl);
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].busy, vecs[i].done);
    end

    // Asynchronous reset between edges mid-RUN at count 4
    drive(0,1,8'd6, 0,0,0);
    drive(0,0,8'd0, 1,0,0);
    drive(0,0,8'd0, 0,0,0);
    drive(0,0,8'd0, 0,0,0);
    check_all("pre_rst", 8'd4, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(0,1,8'd2, 0,0,0);
    check_all("post_rst_load", 8'd2, 1'b0, 1'b0);
    drive(0,0,8'd0, 1,0,0);
    drive(0,0,8'd0, 0,0,0);
    drive(0,0,8'd0, 0,0,0);
    check_all("post_rst_term", 8'd0, 1'b0, 1'b1);

    // Auto-reload select: reload period with macro, one-shot without
    drive(0,1,8'd3, 0,0,1);
    drive(0,0,8'd0, 1,0,1);
    check_all("ar_start", 8'd3, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      logic [7:0] ec;
      logic       eb;
      logic       ed;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      ec = (k % 3 == 0) ? 8'd2 : (k % 3 == 1) ? 8'd1 : 8'd3;
      eb = 1'b1;
      ed = (k % 3 == 2);
`else
      ec = (k == 0) ? 8'd2 : (k == 1) ? 8'd1 : 8'd0;
      eb = (k < 2);
      ed = (k == 2);
`endif
      drive(0,0,8'd0, 0,0,1);
      check_all($sformatf("ar%0d", k), ec, eb, ed);
    end
    drive(1,0,8'd0, 0,0,0);
    check_all("ar_clr", 8'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
